bcd_gate_counter: RTL and testbench
===================================

Name: bcd_gate_counter

Overview:
Parametrised N-digit cascaded BCD event counter with a parallel binary counter, for the frequency-meter datapath. Counts enabled cycles, raises a wrap carry and a sticky overflow, and takes a gapless snapshot on a gate strobe. The snapshot feeds the display/UART path while the live counter restarts for the next gate window.

Parameters:
DIGITS, 8, number of BCD decades (1..10); bcd width = 4*DIGITS
BIN_W, 32, binary counter width (1..32)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; +1 per clk edge while high
clr  in  1  synchronous clear of the live counters and ovf
latch  in  1  snapshot strobe (gate end)
bcd  out  4*DIGITS  live BCD count; digit 0 in bits [3:0]
bin  out  BIN_W  live binary count
carry  out  1  one-cycle pulse on full BCD wrap (all 9s -> all 0s)
ovf  out  1  sticky BCD overflow since the last clr/reset
bcd_q  out  4*DIGITS  latched BCD count
bin_q  out  BIN_W  latched binary count
ovf_q  out  1  latched overflow
q_valid  out  1  one-cycle pulse: snapshot updated

Behaviour:
- Reset (rst_n=0, asynchronous): every output = 0, including bcd_q, bin_q, ovf_q, q_valid and carry. Reset mid-count discards the count and the snapshot immediately.
- All other state changes occur on the rising clk edge.
- Define nxt_bcd = bcd + en in BCD, modulo 10^DIGITS.
- Define nxt_bin = bin + en, modulo 2^BIN_W.
- Define wrap = en && every digit == 9.
- Digit k increments iff en && digits 0..k-1 are all 9. A digit at 9 that increments goes to 0. Digit values 10..15 never occur.
- Live update: bcd <= clr ? 0 : nxt_bcd; bin <= clr ? 0 : nxt_bin. clr has priority over en.
- carry <= wrap, registered. It is high for exactly the cycle in which bcd reads all zeros after a wrap. It is 0 when en=0. A clr in the wrap cycle does not suppress carry.
- ovf <= clr ? 0 : (ovf | wrap).
- bin wraps independently of the BCD chain. A bin wrap does not set ovf or carry.
- Snapshot: when latch=1, bcd_q <= nxt_bcd, bin_q <= nxt_bin, ovf_q <= ovf | wrap.
  - The snapshot includes the count of the latch cycle itself and is taken before clr is applied.
  - latch and clr in the same cycle therefore give a gapless gate: no event is lost or double-counted.
- q_valid <= latch, registered. It goes high in the same cycle the new bcd_q/bin_q become visible, for one cycle per latch cycle.
- When latch=0, bcd_q/bin_q/ovf_q hold their values.
- Back-to-back latch: every latch cycle updates the snapshot and pulses q_valid.
- en=0 holds bcd and bin. clr still clears when en=0.
- Latency: live outputs 1 cycle after en; snapshot 1 cycle after latch. No combinational input-to-output paths.

Decomposition:
- Shared package freq_pkg:
  - DIGIT_W = 4
  - BCD_MAX = 4'd9
  - function bcd_all_nines(vector, DIGITS) returning the all-nines test used for the carry chain
- Sub-module bcd_digit: one decade.
  - Ports: clk, rst_n, clr, inc, q[3:0], at9.
  - Instantiated DIGITS times via generate.
  - inc of digit k = en && AND of at9 of digits 0..k-1.
- The top holds the binary counter, ovf, carry, snapshot registers and q_valid.

Test Plan:
1. Reset with rst_n=0 held 3 cycles after random activity -> all outputs 0. Deassert with en=0 -> all outputs remain 0.
2. DIGITS=8: en=1 for 25 cycles then en=0 -> bcd=0x00000025, bin=25, carry never asserted, ovf=0. Values hold for 10 further cycles.
3. DIGITS=2: 99 en cycles -> bcd=0x99. One more en -> bcd=0x00, bin=100, carry=1 for exactly one cycle, ovf=1 and stays 1 until clr.
4. Count to 41, then one cycle with en=1, latch=1, clr=1 -> next cycle: bcd_q=0x42, bin_q=42, ovf_q=0, q_valid=1 for one cycle, bcd=0, bin=0. The following en cycle gives bcd=0x01.
5. Apply clr=1 with en=1 at count 7 -> bcd=0, bin=0. Repeat with en=0 -> bcd=0, bin=0. Set BIN_W=4 and run 16 en cycles -> bin=0, bcd=0x16, ovf=0.
6. DIGITS=2 at bcd=0x99: en=1 with latch=1 -> bcd_q=0x00, ovf_q=1, carry=1. Pulse rst_n low between clock edges afterwards -> bcd, bcd_q, ovf and ovf_q clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/freq_pkg.sv
// freq_pkg: shared constants and helpers for the frequency-meter counter datapath
package freq_pkg;
  localparam int DIGIT_W = 4;
  localparam int MAX_DIGITS = 10;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  function automatic logic bcd_all_nines(input logic [DIGIT_W*MAX_DIGITS-1:0] v, input int digits);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < digits && v[DIGIT_W*i +: DIGIT_W] != BCD_MAX) r = 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade, counts 0..9 on inc, flags when it sits at 9
module bcd_digit
  import freq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               at9
);
  assign at9 = q == BCD_MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= at9 ? '0 : q + 4'd1;
endmodule

// File: rtl/bcd_gate_counter.sv
// bcd_gate_counter: cascaded BCD + binary event counter with gapless gate snapshot
module bcd_gate_counter
  import freq_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      latch,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]          bin,
  output logic                      carry,
  output logic                      ovf,
  output logic [DIGIT_W*DIGITS-1:0] bcd_q,
  output logic [BIN_W-1:0]          bin_q,
  output logic                      ovf_q,
  output logic                      q_valid
);
  localparam int BW = DIGIT_W * DIGITS;
  logic [DIGITS-1:0] inc, at9;
  logic [BW-1:0]     nxt_bcd;
  logic [BIN_W-1:0]  nxt_bin;
  logic              wrap;
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_digit
      if (k == 0) begin : g_lsd
        assign inc[k] = en;
      end else begin : g_upper
        assign inc[k] = en & (&at9[k-1:0]);
      end
      bcd_digit u_digit (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (inc[k]),
        .q    (bcd[DIGIT_W*k +: DIGIT_W]),
        .at9  (at9[k])
      );
      // Mirror of the digit's own update so the snapshot can include this cycle's event
      assign nxt_bcd[DIGIT_W*k +: DIGIT_W] = !inc[k] ? bcd[DIGIT_W*k +: DIGIT_W] :
                                             at9[k]  ? '0 : bcd[DIGIT_W*k +: DIGIT_W] + 4'd1;
    end
  endgenerate
  assign nxt_bin = bin + BIN_W'(en);
  assign wrap    = en & bcd_all_nines((DIGIT_W*MAX_DIGITS)'(bcd), DIGITS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bin     <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
      bcd_q   <= '0;
      bin_q   <= '0;
      ovf_q   <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      bin     <= clr ? '0 : nxt_bin;
      carry   <= wrap;
      ovf     <= clr ? 1'b0 : ovf | wrap;
      q_valid <= latch;
      if (latch) begin
        bcd_q <= nxt_bcd;
        bin_q <= nxt_bin;
        ovf_q <= ovf | wrap;
      end
    end
endmodule

// File: tb/tb_bcd_gate_counter.sv
// tb_bcd_gate_counter: directed vector table plus hand sequences over three parameterisations
module tb_bcd_gate_counter;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, latch = 1'b0;
  logic [31:0] a_bcd, a_bin, a_bcd_q, a_bin_q;
  logic        a_carry, a_ovf, a_ovf_q, a_qv;
  logic [7:0]  b_bcd, b_bin, b_bcd_q, b_bin_q;
  logic        b_carry, b_ovf, b_ovf_q, b_qv;
  logic [31:0] c_bcd, c_bcd_q;
  logic [3:0]  c_bin, c_bin_q;
  logic        c_carry, c_ovf, c_ovf_q, c_qv;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  bcd_gate_counter #(.DIGITS(8), .BIN_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .latch(latch),
    .bcd(a_bcd), .bin(a_bin), .carry(a_carry), .ovf(a_ovf),
    .bcd_q(a_bcd_q), .bin_q(a_bin_q), .ovf_q(a_ovf_q), .q_valid(a_qv));
  bcd_gate_counter #(.DIGITS(2), .BIN_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .latch(latch),
    .bcd(b_bcd), .bin(b_bin), .carry(b_carry), .ovf(b_ovf),
    .bcd_q(b_bcd_q), .bin_q(b_bin_q), .ovf_q(b_ovf_q), .q_valid(b_qv));
  bcd_gate_counter #(.DIGITS(8), .BIN_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .latch(latch),
    .bcd(c_bcd), .bin(c_bin), .carry(c_carry), .ovf(c_ovf),
    .bcd_q(c_bcd_q), .bin_q(c_bin_q), .ovf_q(c_ovf_q), .q_valid(c_qv));

  typedef struct {
    logic        en, clr, latch;
    logic [31:0] bcd, bin, bcd_q, bin_q;
    logic        qv;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic step(input logic e, input logic c, input logic l);
    en = e; clr = c; latch = l;
    @(posedge clk);
    #1;
    en = 1'b0; clr = 1'b0; latch = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  vec_t tbl[11];
  logic saw_carry;

  initial begin
    // gate-style sequence on the 8-digit instance, starting from a cleared count
    tbl[0]  = '{1,0,0, 32'h1, 1, 0, 0, 0};
    tbl[1]  = '{1,0,0, 32'h2, 2, 0, 0, 0};
    tbl[2]  = '{0,0,0, 32'h2, 2, 0, 0, 0};
    tbl[3]  = '{1,0,1, 32'h3, 3, 32'h3, 3, 1};
    tbl[4]  = '{0,0,0, 32'h3, 3, 32'h3, 3, 0};
    tbl[5]  = '{1,1,0, 32'h0, 0, 32'h3, 3, 0};
    tbl[6]  = '{0,1,0, 32'h0, 0, 32'h3, 3, 0};
    tbl[7]  = '{1,0,1, 32'h1, 1, 32'h1, 1, 1};
    tbl[8]  = '{1,0,1, 32'h2, 2, 32'h2, 2, 1};
    tbl[9]  = '{1,1,1, 32'h0, 0, 32'h3, 3, 1};
    tbl[10] = '{1,0,0, 32'h1, 1, 32'h3, 3, 0};

    // test 1: random activity then reset held 3 cycles
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom));
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_all", {a_bcd, a_bin}, 64'h0);
    chk("rst_a_q", {a_bcd_q, a_bin_q}, 64'h0);
    chk("rst_flags", {a_carry, a_ovf, a_ovf_q, a_qv, b_carry, b_ovf, b_ovf_q, b_qv}, 64'h0);
    rst_n = 1'b1;
    step(0, 0, 0);
    chk("rst_release_hold", {a_bcd, a_bin}, 64'h0);
    chk("rst_release_flags", {a_carry, a_ovf, a_qv, a_bcd_q}, 64'h0);

    // test 2: 25 counts then hold
    saw_carry = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(1, 0, 0);
      saw_carry |= a_carry;
    end
    chk("cnt25_bcd", a_bcd, 32'h25);
    chk("cnt25_bin", a_bin, 25);
    chk("cnt25_nocarry", {saw_carry, a_ovf}, 0);
    repeat (10) step(0, 0, 0);
    chk("hold_bcd", {a_bcd, a_bin}, {32'h25, 32'd25});

    // table-driven gate sequence
    step(0, 1, 0);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].latch);
      chk($sformatf("tbl%0d_live", i), {a_bcd, a_bin}, {tbl[i].bcd, tbl[i].bin});
      chk($sformatf("tbl%0d_snap", i), {a_bcd_q, a_bin_q}, {tbl[i].bcd_q, tbl[i].bin_q});
      chk($sformatf("tbl%0d_flags", i), {a_qv, a_ovf_q, a_carry, a_ovf}, {tbl[i].qv, 3'b000});
    end

    // test 3: two-digit wrap
    step(0, 1, 0);
    run(99);
    chk("d2_99", {b_bcd, b_carry, b_ovf}, {8'h99, 2'b00});
    step(1, 0, 0);
    chk("d2_wrap", {b_bcd, b_bin, b_carry, b_ovf}, {8'h00, 8'd100, 2'b11});
    step(0, 0, 0);
    chk("d2_carry_pulse", {b_carry, b_ovf}, 2'b01);
    run(3);
    chk("d2_ovf_sticky", {b_bcd, b_carry, b_ovf}, {8'h03, 2'b01});
    step(0, 1, 0);
    chk("d2_ovf_clr", {b_bcd, b_bin, b_ovf}, 17'h0);

    // test 4: gapless gate at count 41
    run(41);
    chk("g41", a_bcd, 32'h41);
    step(1, 1, 1);
    chk("g42_snap", {a_bcd_q, a_bin_q, a_ovf_q, a_qv}, {32'h42, 32'd42, 2'b01});
    chk("g42_live", {a_bcd, a_bin}, 64'h0);
    step(1, 0, 0);
    chk("g_next", {a_bcd, a_qv, a_bcd_q}, {32'h1, 1'b0, 32'h42});

    // test 5: clr priority and 4-bit binary wrap
    step(0, 1, 0);
    run(7);
    step(1, 1, 0);
    chk("clr_en", {a_bcd, a_bin}, 64'h0);
    run(7);
    step(0, 1, 0);
    chk("clr_noen", {a_bcd, a_bin}, 64'h0);
    run(16);
    chk("binw4", {c_bin, c_bcd, c_ovf, c_carry}, {4'h0, 32'h16, 2'b00});

    // test 6: wrap with latch, then asynchronous reset between edges
    step(0, 1, 0);
    run(99);
    step(1, 0, 1);
    chk("d2_wrap_latch", {b_bcd_q, b_ovf_q, b_carry, b_qv}, {8'h00, 3'b111});
    chk("d2_wrap_ovf", b_ovf, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {b_bcd, b_bcd_q, b_ovf, b_ovf_q, b_carry}, 0);
    #2 rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
